hist_peak_finder: RTL and testbench
===================================

// Module: hist_peak_finder
// PURPOSE
//  Downstream consumer of the histogramming readout stream (data_out/valid_out/last_bin).
//  Scans one histogram frame, one bin count per beat. Produces a summary record per frame:
//  peak bin index, peak count, total count and number of non-zero bins.
//  The record is presented on a valid/ready port. The upstream stream has no backpressure,
//  so a double-buffered result stage lets accumulation continue while a record waits.
// PARAMETERS
//  COUNT_W  8   width of one bin count (matches histogram data_out)
//  BIN_W    8   width of bin index; max frame length 2**BIN_W beats
//  SUM_W    16  width of total-count accumulator (saturating)
// PORTS
//  clk          in   1        clock, all logic rising-edge
//  rst_n        in   1        reset, synchronous, active-low
//  bin_count    in   COUNT_W  bin count of current beat
//  bin_valid    in   1        beat qualifier (histogram valid_out)
//  bin_last     in   1        final bin of frame; only meaningful with bin_valid
//  res_valid    out  1        summary record available
//  res_ready    in   1        consumer accepts record
//  peak_bin     out  BIN_W    index of largest count (lowest index on tie)
//  peak_count   out  COUNT_W  largest count in frame
//  total_count  out  SUM_W    sum of counts, saturating at 2**SUM_W-1
//  nz_bins      out  BIN_W+1  number of beats with bin_count != 0
//  flags        out  3        {overrun, len_err, sum_sat} for this record
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, accumulator FSM -> IDLE, result stage EMPTY.
//  Accumulator FSM: IDLE / ACCUM.
//   IDLE: bin_valid -> load first beat as index 0: max=count, peak=0, sum=count, nz=(count!=0).
//         Next state is ACCUM unless bin_last=1, which closes the frame immediately.
//   ACCUM: each bin_valid beat:
//     - idx += 1
//     - if count > max (strict): max=count, peak=idx
//     - sum += count (saturating; sticky sum_sat)
//     - nz += (count!=0)
//   Frame close -> IDLE on:
//     - bin_last=1, or
//     - the beat with idx==2**BIN_W-1 and bin_last=0; this sets len_err for the record.
//   Beats with bin_valid=0 are ignored; idx does not advance; no timeout.
//  Result stage: EMPTY / FULL; record registered.
//   res_valid rises the cycle after the closing beat (latency 1).
//   Outputs stable while res_valid=1 and res_ready=0.
//   Transfer when res_valid & res_ready at a clk edge; stage -> EMPTY unless a frame closes same cycle.
//  Simultaneous close + transfer: new record loads, res_valid stays 1, overrun=0.
//  Close while FULL and not transferring: record overwritten, overrun=1 in the new record.
//  Back-to-back frames: a beat in IDLE the cycle after close starts the next frame; no gap needed.
//  res_ready while EMPTY: no effect. Outputs are don't-care-free: held at last value when res_valid=0.
//  Reset mid-frame or mid-hold: partial frame and pending record discarded, no record emitted.
// TESTING
//  4 beats {3,9,9,0}, last on 4th -> 1 cycle later res_valid=1, peak_bin=1, peak_count=9, total=21, nz=3, flags=0.
//  Single beat {0} with last -> peak_bin=0, peak_count=0, total=0, nz=0, res_valid next cycle.
//  256 beats of 255 with no last -> forced close: len_err=1, total=65280, nz=256, peak_bin=0.
//  SUM_W=8, beats {200,100} with last -> total=255, sum_sat=1.
//  Two frames {1,5}/{7,2}, res_ready=0 -> second record peak_bin=0, peak_count=7, overrun=1.
//  Same two frames with res_ready pulsed on second close -> overrun=0.
//  Reset mid-frame -> res_valid stays 0; next full frame reports only post-reset beats.

Source files
------------

// File: rtl/hist_peak_finder.sv
// rtl/hist_peak_finder.sv - per-frame histogram summary (peak, total, non-zero bins) with double-buffered result
module hist_peak_finder #(
    parameter int COUNT_W = 8,
    parameter int BIN_W   = 8,
    parameter int SUM_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] bin_count,
    input  logic               bin_valid,
    input  logic               bin_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BIN_W-1:0]   peak_bin,
    output logic [COUNT_W-1:0] peak_count,
    output logic [SUM_W-1:0]   total_count,
    output logic [BIN_W:0]     nz_bins,
    output logic [2:0]         flags
);

    localparam int EXT_W = ((SUM_W > COUNT_W) ? SUM_W : COUNT_W) + 1;
    localparam logic [BIN_W-1:0] IDX_LAST = '1;
    localparam logic [EXT_W-1:0] SUM_MAX  = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

    typedef enum logic {S_IDLE, S_ACCUM} acc_state_t;

    acc_state_t         r_state;
    logic [BIN_W-1:0]   r_idx;
    logic [COUNT_W-1:0] r_max;
    logic [BIN_W-1:0]   r_peak;
    logic [SUM_W-1:0]   r_sum;
    logic               r_sat;
    logic [BIN_W:0]     r_nz;

    logic               r_res_valid;
    logic [BIN_W-1:0]   r_res_peak;
    logic [COUNT_W-1:0] r_res_max;
    logic [SUM_W-1:0]   r_res_sum;
    logic [BIN_W:0]     r_res_nz;
    logic [2:0]         r_res_flags;

    logic               w_first;
    logic [BIN_W-1:0]   w_beat_idx;
    logic               w_new_peak;
    logic [COUNT_W-1:0] w_max_nx;
    logic [BIN_W-1:0]   w_peak_nx;
    logic [SUM_W-1:0]   w_sum_base;
    logic [EXT_W-1:0]   w_sum_ext;
    logic               w_sum_ovf;
    logic [SUM_W-1:0]   w_sum_nx;
    logic               w_sat_nx;
    logic [BIN_W:0]     w_nz_nx;
    logic               w_len_err;
    logic               w_close;
    logic               w_xfer;

    // The first beat of a frame replaces the running state instead of merging into it.
    assign w_first    = (r_state == S_IDLE);
    assign w_beat_idx = w_first ? '0 : r_idx + 1'b1;
    assign w_new_peak = w_first | (bin_count > r_max);
    assign w_max_nx   = w_new_peak ? bin_count : r_max;
    assign w_peak_nx  = w_new_peak ? w_beat_idx : r_peak;

    assign w_sum_base = w_first ? '0 : r_sum;
    assign w_sum_ext  = EXT_W'(w_sum_base) + EXT_W'(bin_count);
    assign w_sum_ovf  = (w_sum_ext > SUM_MAX);
    assign w_sum_nx   = w_sum_ovf ? '1 : w_sum_ext[SUM_W-1:0];
    assign w_sat_nx   = (~w_first & r_sat) | w_sum_ovf;
    assign w_nz_nx    = (w_first ? '0 : r_nz) + (BIN_W+1)'(bin_count != '0);

    // A frame that fills every index without bin_last is closed by force and flagged.
    assign w_len_err  = (w_beat_idx == IDX_LAST) & ~bin_last;
    assign w_close    = bin_valid & (bin_last | (w_beat_idx == IDX_LAST));
    assign w_xfer     = r_res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_max   <= '0;
            r_peak  <= '0;
            r_sum   <= '0;
            r_sat   <= 1'b0;
            r_nz    <= '0;
        end else if (bin_valid) begin
            r_idx   <= w_beat_idx;
            r_max   <= w_max_nx;
            r_peak  <= w_peak_nx;
            r_sum   <= w_sum_nx;
            r_sat   <= w_sat_nx;
            r_nz    <= w_nz_nx;
            r_state <= w_close ? S_IDLE : S_ACCUM;
        end
    end

    // Result stage: a closing frame always wins; overrun marks a record that was never taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_peak  <= '0;
            r_res_max   <= '0;
            r_res_sum   <= '0;
            r_res_nz    <= '0;
            r_res_flags <= '0;
        end else if (w_close) begin
            r_res_valid <= 1'b1;
            r_res_peak  <= w_peak_nx;
            r_res_max   <= w_max_nx;
            r_res_sum   <= w_sum_nx;
            r_res_nz    <= w_nz_nx;
            r_res_flags <= {r_res_valid & ~res_ready, w_len_err, w_sat_nx};
        end else if (w_xfer) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid   = r_res_valid;
    assign peak_bin    = r_res_peak;
    assign peak_count  = r_res_max;
    assign total_count = r_res_sum;
    assign nz_bins     = r_res_nz;
    assign flags       = r_res_flags;

endmodule

// File: tb/tb_hist_peak_finder.sv
// tb/tb_hist_peak_finder.sv - table, directed and randomized checks of hist_peak_finder against a frame-level model
module tb_hist_peak_finder;

    logic        clk = 1'b0;
    logic        rst_n, bin_valid, bin_last, res_ready;
    logic [7:0]  bin_count;

    logic        res_valid,  res_valid8;
    logic [7:0]  peak_bin,   peak_bin8;
    logic [7:0]  peak_count, peak_count8;
    logic [15:0] total_count;
    logic [7:0]  total_count8;
    logic [8:0]  nz_bins,    nz_bins8;
    logic [2:0]  flags,      flags8;

    always #5 clk = ~clk;

    hist_peak_finder u_dut (
        .clk(clk), .rst_n(rst_n), .bin_count(bin_count), .bin_valid(bin_valid),
        .bin_last(bin_last), .res_valid(res_valid), .res_ready(res_ready),
        .peak_bin(peak_bin), .peak_count(peak_count), .total_count(total_count),
        .nz_bins(nz_bins), .flags(flags)
    );

    hist_peak_finder #(.COUNT_W(8), .BIN_W(8), .SUM_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bin_count(bin_count), .bin_valid(bin_valid),
        .bin_last(bin_last), .res_valid(res_valid8), .res_ready(res_ready),
        .peak_bin(peak_bin8), .peak_count(peak_count8), .total_count(total_count8),
        .nz_bins(nz_bins8), .flags(flags8)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: beats are collected, the record is computed when the frame ends.
    int         frame_q[$];
    logic       m_valid;
    int         m_pb, m_pc, m_tot, m_tot8, m_nz;
    logic [2:0] m_fl, m_fl8;

    typedef struct {
        int len;
        int beats[4];
        int pb, pc, tot, nz, fl, tot8, fl8;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit closed = 0;
        if (!rst_n) begin
            frame_q.delete();
            m_valid = 0; m_pb = 0; m_pc = 0; m_tot = 0; m_tot8 = 0; m_nz = 0;
            m_fl = '0; m_fl8 = '0;
            return;
        end
        if (bin_valid) begin
            frame_q.push_back(int'(bin_count));
            if (bin_last || frame_q.size() == 256) begin
                int sum = 0, best = -1, pb = 0, nz = 0;
                bit ovr;
                foreach (frame_q[i]) begin
                    sum += frame_q[i];
                    if (frame_q[i] > best) begin best = frame_q[i]; pb = i; end
                    if (frame_q[i] != 0) nz++;
                end
                ovr    = m_valid && !res_ready;
                m_pb   = pb;
                m_pc   = best;
                m_nz   = nz;
                m_tot  = (sum > 65535) ? 65535 : sum;
                m_tot8 = (sum > 255) ? 255 : sum;
                m_fl   = {ovr, !bin_last, sum > 65535};
                m_fl8  = {ovr, !bin_last, sum > 255};
                m_valid = 1;
                frame_q.delete();
                closed = 1;
            end
        end
        if (!closed && m_valid && res_ready) m_valid = 0;
    endtask

    task automatic check_outputs();
        chk("res_valid",    res_valid,    m_valid);
        chk("peak_bin",     peak_bin,     m_pb);
        chk("peak_count",   peak_count,   m_pc);
        chk("total_count",  total_count,  m_tot);
        chk("nz_bins",      nz_bins,      m_nz);
        chk("flags",        flags,        m_fl);
        chk("res_valid8",   res_valid8,   m_valid);
        chk("peak_bin8",    peak_bin8,    m_pb);
        chk("total_count8", total_count8, m_tot8);
        chk("flags8",       flags8,       m_fl8);
    endtask

    task automatic cycle(input logic v, input logic last, input int cnt, input logic rdy, input logic rstn);
        bin_valid = v;
        bin_last  = last;
        bin_count = 8'(cnt);
        res_ready = rdy;
        rst_n     = rstn;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        vecs[0] = '{4, '{3, 9, 9, 0},         1,   9,   21, 3, 0,   21, 0};
        vecs[1] = '{1, '{0, 0, 0, 0},         0,   0,    0, 0, 0,    0, 0};
        vecs[2] = '{3, '{2, 0, 8, 0},         2,   8,   10, 2, 0,   10, 0};
        vecs[3] = '{4, '{255, 255, 255, 255}, 0, 255, 1020, 4, 0,  255, 1};
        vecs[4] = '{4, '{0, 0, 0, 4},         3,   4,    4, 1, 0,    4, 0};
        vecs[5] = '{2, '{200, 100, 0, 0},     0, 200,  300, 2, 0,  255, 1};

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_total",     total_count, 0);
        cycle(1, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);

        // Frames back to back with the consumer always ready.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < vecs[k].len; j++)
                cycle(1, j == vecs[k].len - 1, vecs[k].beats[j], 1, 1);
            chk($sformatf("vec%0d_valid", k), res_valid,    1);
            chk($sformatf("vec%0d_peak",  k), peak_bin,     vecs[k].pb);
            chk($sformatf("vec%0d_pc",    k), peak_count,   vecs[k].pc);
            chk($sformatf("vec%0d_total", k), total_count,  vecs[k].tot);
            chk($sformatf("vec%0d_nz",    k), nz_bins,      vecs[k].nz);
            chk($sformatf("vec%0d_flags", k), flags,        vecs[k].fl);
            chk($sformatf("vec%0d_tot8",  k), total_count8, vecs[k].tot8);
            chk($sformatf("vec%0d_fl8",   k), flags8,       vecs[k].fl8);
        end
        cycle(0, 0, 0, 1, 1);
        chk("drained_valid", res_valid, 0);

        // Forced close after 256 beats with no bin_last.
        for (int j = 0; j < 256; j++) cycle(1, 0, 255, 1, 1);
        chk("len_valid", res_valid,    1);
        chk("len_total", total_count,  65280);
        chk("len_nz",    nz_bins,      256);
        chk("len_peak",  peak_bin,     0);
        chk("len_flags", flags,        3'b010);
        chk("len_fl8",   flags8,       3'b011);
        cycle(0, 0, 0, 1, 1);

        // Second frame closes while the first record is still held.
        cycle(1, 0, 1, 0, 1); cycle(1, 1, 5, 0, 1);
        cycle(1, 0, 7, 0, 1); cycle(1, 1, 2, 0, 1);
        chk("ovr_peak",  peak_bin,   0);
        chk("ovr_pc",    peak_count, 7);
        chk("ovr_flags", flags,      3'b100);
        for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0, 1);
        chk("ovr_hold", res_valid, 1);
        cycle(0, 0, 0, 1, 1);

        // Same frames, consumer takes the first record on the second close.
        cycle(1, 0, 1, 0, 1); cycle(1, 1, 5, 0, 1);
        cycle(1, 0, 7, 0, 1); cycle(1, 1, 2, 1, 1);
        chk("xfer_valid", res_valid, 1);
        chk("xfer_pc",    peak_count, 7);
        chk("xfer_flags", flags,     3'b000);
        cycle(0, 0, 0, 1, 1);

        // Reset mid-frame discards the partial frame.
        cycle(1, 0, 9, 1, 1); cycle(1, 0, 9, 1, 1);
        cycle(0, 0, 0, 1, 0);
        chk("rst_mid_valid", res_valid, 0);
        cycle(1, 0, 1, 1, 1); cycle(1, 1, 2, 1, 1);
        chk("rst_mid_total", total_count, 3);
        chk("rst_mid_pc",    peak_count,  2);

        for (int n = 0; n < 4000; n++) begin
            logic v, last, rdy, rstn;
            int   cnt;
            v    = ($urandom_range(0, 3) != 0);
            last = (n >= 1500 && n < 2200) ? 1'b0 : ($urandom_range(0, 19) == 0);
            cnt  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            rdy  = ($urandom_range(0, 2) != 0);
            rstn = ($urandom_range(0, 599) != 0);
            cycle(v, last, cnt, rdy, rstn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
